// File: rtl/uart_cfg.sv
// Configurable full-duplex UART: 5..9 data bits, optional even/odd parity, 1 or 2 stop bits,
// runtime baud divisor, with parity/framing/overrun reporting and break handling on receive.
module uart_cfg #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned BAUD_W    = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BAUD_W-1:0]    baud_div,
  input  logic                 RX,
  output logic                 TX,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  input  logic                 clr_rx_rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] BRK   = 3'd5;

  localparam bit         HAS_PAR   = (PARITY != 0);
  localparam bit         ODD       = (PARITY == 2);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic [BAUD_W-1:0] div_c;
  assign div_c = (baud_div < BAUD_W'(3)) ? BAUD_W'(3) : baud_div;

  // ---------------- transmitter ----------------
  logic [2:0]           tx_state_q;
  logic [BAUD_W-1:0]    tx_cnt_q, tx_div_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q;
  logic [3:0]           tx_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= IDLE;
      TX         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_idx_q   <= '0;
    end else begin
      case (tx_state_q)
        IDLE: if (trmt) begin
          tx_state_q <= START;
          TX         <= 1'b0;
          tx_busy    <= 1'b1;
          tx_done    <= 1'b0;
          tx_div_q   <= div_c;
          tx_cnt_q   <= div_c;
          tx_sh_q    <= tx_data;
          tx_par_q   <= (^tx_data) ^ ODD;
        end
        default: if (tx_cnt_q != '0) begin
          tx_cnt_q <= tx_cnt_q - 1'b1;
        end else begin
          // Bit period over: drive the next bit level for a fresh full period.
          tx_cnt_q <= tx_div_q;
          case (tx_state_q)
            START: begin
              tx_state_q <= DATA;
              TX         <= tx_sh_q[0];
              tx_idx_q   <= '0;
            end
            DATA: if (tx_idx_q == LAST_DATA) begin
              if (HAS_PAR) begin
                tx_state_q <= PAR;
                TX         <= tx_par_q;
              end else begin
                tx_state_q <= STOP;
                TX         <= 1'b1;
                tx_idx_q   <= '0;
              end
            end else begin
              tx_idx_q <= tx_idx_q + 1'b1;
              tx_sh_q  <= tx_sh_q >> 1;
              TX       <= tx_sh_q[1];
            end
            PAR: begin
              tx_state_q <= STOP;
              TX         <= 1'b1;
              tx_idx_q   <= '0;
            end
            default: if (tx_idx_q == LAST_STOP) begin
              tx_state_q <= IDLE;
              tx_busy    <= 1'b0;
              tx_done    <= 1'b1;
            end else begin
              tx_idx_q <= tx_idx_q + 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           rx_state_q;
  logic [BAUD_W-1:0]    rx_cnt_q, rx_div_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_pbit_q, rx_stop_bad_q;
  logic [3:0]           rx_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q    <= IDLE;
      rx_cnt_q      <= '0;
      rx_div_q      <= '0;
      rx_sh_q       <= '0;
      rx_pbit_q     <= 1'b0;
      rx_stop_bad_q <= 1'b0;
      rx_idx_q      <= '0;
      rx_data       <= '0;
      rx_rdy        <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      // A frame completing on this edge overrides the acknowledge below.
      if (clr_rx_rdy) begin
        rx_rdy  <= 1'b0;
        overrun <= 1'b0;
      end
      case (rx_state_q)
        IDLE: if (!rx_s_q) begin
          rx_state_q <= START;
          rx_div_q   <= div_c;
          rx_cnt_q   <= div_c >> 1;
        end
        BRK: if (rx_s_q) rx_state_q <= IDLE;
        default: if (rx_cnt_q != '0) begin
          rx_cnt_q <= rx_cnt_q - 1'b1;
        end else begin
          rx_cnt_q <= rx_div_q;
          case (rx_state_q)
            START: if (rx_s_q) begin
              rx_state_q <= IDLE;
            end else begin
              rx_state_q <= DATA;
              rx_idx_q   <= '0;
            end
            DATA: begin
              rx_sh_q <= {rx_s_q, rx_sh_q[DATA_BITS-1:1]};
              if (rx_idx_q == LAST_DATA) begin
                rx_state_q    <= HAS_PAR ? PAR : STOP;
                rx_idx_q      <= '0;
                rx_stop_bad_q <= 1'b0;
              end else begin
                rx_idx_q <= rx_idx_q + 1'b1;
              end
            end
            PAR: begin
              rx_pbit_q  <= rx_s_q;
              rx_state_q <= STOP;
            end
            default: if (rx_idx_q != LAST_STOP) begin
              rx_idx_q      <= rx_idx_q + 1'b1;
              rx_stop_bad_q <= rx_stop_bad_q | ~rx_s_q;
            end else begin
              rx_data    <= rx_sh_q;
              parity_err <= HAS_PAR && (rx_pbit_q != ((^rx_sh_q) ^ ODD));
              frame_err  <= rx_stop_bad_q | ~rx_s_q;
              rx_rdy     <= 1'b1;
              overrun    <= rx_rdy & ~clr_rx_rdy;
              // A line still low here is a break: report one frame, then wait for idle.
              rx_state_q <= rx_s_q ? IDLE : BRK;
            end
          endcase
        end
      endcase
    end
  end

endmodule
